register_alias_table: RTL and testbench

Speculative and architectural register alias tables for the rename stage. Serves the two source-operand lookups and the destination re-map that Rename issues each cycle. Returns the displaced alias so the ROB can free it at commit, and tracks committed mappings in a shadow table. On a pipeline flush it restores the speculative table from that shadow table in one cycle.

---
 rtl/register_alias_table.sv | 91 +++++++++
 tb/tb_register_alias_table.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/register_alias_table.sv
// Speculative and committed register alias tables for the rename stage.
// Define RAT_X0_HARDWIRE_EN to pin areg 0 to preg 0 in both tables.
package core_pkg;
    parameter int NUM_AREGS = 32;
    parameter int NUM_PREGS = 64;
endpackage

module register_alias_table
    import core_pkg::*;
#(
    parameter int  NUM_AREGS = core_pkg::NUM_AREGS,
    parameter int  NUM_PREGS = core_pkg::NUM_PREGS,
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0][AW-1:0] rd_areg,
    output logic [1:0][PW-1:0] rd_preg,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_areg,
    input  logic [PW-1:0]      wr_preg,
    output logic [PW-1:0]      wr_old_preg,
    input  logic               commit_en,
    input  logic [AW-1:0]      commit_areg,
    input  logic [PW-1:0]      commit_preg,
    input  logic               flush,
    output logic               recovering
);

    logic [PW-1:0] spec_map [NUM_AREGS];
    logic [PW-1:0] arch_map [NUM_AREGS];
    logic [PW-1:0] spec_nxt [NUM_AREGS];
    logic [PW-1:0] arch_nxt [NUM_AREGS];

    logic       wr_x0;
    logic       cm_x0;
    logic [1:0] rd_x0;
    logic       wr_ok;
    logic       cm_ok;

`ifdef RAT_X0_HARDWIRE_EN
    assign wr_x0    = (wr_areg == '0);
    assign cm_x0    = (commit_areg == '0);
    assign rd_x0[0] = (rd_areg[0] == '0);
    assign rd_x0[1] = (rd_areg[1] == '0);
`else
    assign wr_x0 = 1'b0;
    assign cm_x0 = 1'b0;
    assign rd_x0 = 2'b00;
`endif

    // Rename writes are held off for the whole flush/recovery window.
    assign wr_ok = wr_en && !recovering && !wr_x0;
    assign cm_ok = commit_en && !cm_x0;

    always_comb begin
        rd_preg[0]  = rd_x0[0] ? '0 : spec_map[rd_areg[0]];
        rd_preg[1]  = rd_x0[1] ? '0 : spec_map[rd_areg[1]];
        wr_old_preg = wr_x0 ? '0 : spec_map[wr_areg];
    end

    // Flush restores from the committed table with this cycle's commit merged.
    always_comb begin
        arch_nxt = arch_map;
        if (cm_ok) begin
            arch_nxt[commit_areg] = commit_preg;
        end
        spec_nxt = spec_map;
        if (flush) begin
            spec_nxt = arch_nxt;
        end else if (wr_ok) begin
            spec_nxt[wr_areg] = wr_preg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                spec_map[i] <= PW'(i);
                arch_map[i] <= PW'(i);
            end
            recovering <= 1'b0;
        end else begin
            spec_map   <= spec_nxt;
            arch_map   <= arch_nxt;
            recovering <= flush;
        end
    end

endmodule

// File: tb/tb_register_alias_table.sv
// Directed self-checking bench for register_alias_table.
// Inputs change on the falling edge; outputs are checked before the rising edge.
module tb_register_alias_table;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  rd_areg;
    logic [1:0][5:0]  rd_preg;
    logic             wr_en;
    logic [4:0]       wr_areg;
    logic [5:0]       wr_preg;
    logic [5:0]       wr_old_preg;
    logic             commit_en;
    logic [4:0]       commit_areg;
    logic [5:0]       commit_preg;
    logic             flush;
    logic             recovering;

    int total = 0;
    int bad   = 0;

    register_alias_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_areg     (rd_areg),
        .rd_preg     (rd_preg),
        .wr_en       (wr_en),
        .wr_areg     (wr_areg),
        .wr_preg     (wr_preg),
        .wr_old_preg (wr_old_preg),
        .commit_en   (commit_en),
        .commit_areg (commit_areg),
        .commit_preg (commit_preg),
        .flush       (flush),
        .recovering  (recovering)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        commit_en = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        int x0_exp;
`ifdef RAT_X0_HARDWIRE_EN
        x0_exp = 0;
`else
        x0_exp = 33;
`endif
        rst_n       = 1'b1;
        rd_areg[0]  = 5'd5;
        rd_areg[1]  = 5'd31;
        wr_areg     = 5'd7;
        wr_preg     = '0;
        commit_areg = '0;
        commit_preg = '0;
        idle();
        #1 rst_n = 1'b0;
        #1 chk("rst_rec", 32'(recovering), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rd0", 32'(rd_preg[0]), 5);
        chk("rst_rd1", 32'(rd_preg[1]), 31);
        chk("rst_old", 32'(wr_old_preg), 7);
        chk("rst_rec2", 32'(recovering), 0);

        // write with same-cycle read of the destination
        @(negedge clk);
        wr_en = 1'b1; wr_areg = 5'd3; wr_preg = 6'd40; rd_areg[0] = 5'd3;
        #1;
        chk("wr_noforward", 32'(rd_preg[0]), 3);
        chk("wr_old", 32'(wr_old_preg), 3);
        @(negedge clk);
        idle();
        #1 chk("wr_visible", 32'(rd_preg[0]), 40);

        // commit 3->40, write 3->41, flush restores 40
        @(negedge clk);
        commit_en = 1'b1; commit_areg = 5'd3; commit_preg = 6'd40;
        @(negedge clk);
        idle();
        wr_en = 1'b1; wr_areg = 5'd3; wr_preg = 6'd41;
        #1 chk("old_before_41", 32'(wr_old_preg), 40);
        @(negedge clk);
        idle();
        #1 chk("spec_41", 32'(rd_preg[0]), 41);
        flush = 1'b1;
        @(negedge clk);
        idle();
        wr_en = 1'b1; wr_areg = 5'd9; wr_preg = 6'd20; rd_areg[1] = 5'd9;
        #1;
        chk("flush_restore", 32'(rd_preg[0]), 40);
        chk("flush_rec", 32'(recovering), 1);
        @(negedge clk);
        idle();
        #1;
        chk("rec_wr_dropped", 32'(rd_preg[1]), 9);
        chk("rec_clear", 32'(recovering), 0);
        wr_en = 1'b1; wr_areg = 5'd9; wr_preg = 6'd21;
        @(negedge clk);
        idle();
        #1 chk("wr_after_rec", 32'(rd_preg[1]), 21);

        // flush with same-cycle commit and write to areg 12
        rd_areg[0] = 5'd12;
        flush = 1'b1;
        commit_en = 1'b1; commit_areg = 5'd12; commit_preg = 6'd50;
        wr_en = 1'b1; wr_areg = 5'd12; wr_preg = 6'd51;
        #1 chk("pre_flush12", 32'(rd_preg[0]), 12);
        @(negedge clk);
        idle();
        #1;
        chk("flush_commit_merge", 32'(rd_preg[0]), 50);
        chk("flush_drop_9", 32'(rd_preg[1]), 9);
        chk("flush2_rec", 32'(recovering), 1);
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1 chk("held_rec", 32'(recovering), 1);
        @(negedge clk);
        #1 chk("held_rec_clear", 32'(recovering), 0);

        // areg 0 renaming
        wr_en = 1'b1; wr_areg = 5'd0; wr_preg = 6'd33; rd_areg[0] = 5'd0;
        @(negedge clk);
        idle();
        #1;
        chk("x0_read", 32'(rd_preg[0]), 32'(x0_exp));
        chk("x0_old", 32'(wr_old_preg), 32'(x0_exp));
        commit_en = 1'b1; commit_areg = 5'd0; commit_preg = 6'd33;
        @(negedge clk);
        idle();
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1 chk("x0_arch", 32'(rd_preg[0]), 32'(x0_exp));
        @(negedge clk);

        // async reset during recovery
        wr_en = 1'b1; wr_areg = 5'd1; wr_preg = 6'd60;
        commit_en = 1'b1; commit_areg = 5'd1; commit_preg = 6'd60;
        @(negedge clk);
        wr_areg = 5'd2; wr_preg = 6'd61;
        commit_areg = 5'd2; commit_preg = 6'd61;
        @(negedge clk);
        idle();
        wr_en = 1'b1; wr_areg = 5'd4; wr_preg = 6'd62;
        @(negedge clk);
        idle();
        rd_areg[0] = 5'd1; rd_areg[1] = 5'd2; wr_areg = 5'd4;
        #1;
        chk("pre_rst_rd1", 32'(rd_preg[0]), 60);
        chk("pre_rst_old4", 32'(wr_old_preg), 62);
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("pre_rst_rec", 32'(recovering), 1);
        chk("pre_rst_rd2", 32'(rd_preg[1]), 61);
        rst_n = 1'b0;
        #1;
        chk("arst_rec", 32'(recovering), 0);
        chk("arst_rd1", 32'(rd_preg[0]), 1);
        chk("arst_rd2", 32'(rd_preg[1]), 2);
        chk("arst_old4", 32'(wr_old_preg), 4);
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("arst_arch1", 32'(rd_preg[0]), 1);
        chk("arst_arch2", 32'(rd_preg[1]), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
